// File: rtl/csr_regfile.sv
// csr_regfile: machine-mode CSR file with read-modify-write CSR ops, trap entry and MRET redirects.
// Define COUNTERS_EN to add the mcycle/minstret counters and the read-only cycle alias.
`ifndef REG_DATA_SIZE
`define REG_DATA_SIZE 31
`endif
`ifndef REG_ADDR_SIZE
`define REG_ADDR_SIZE 4
`endif
`ifndef EX_WIDTH
`define EX_WIDTH 4
`endif

module csr_regfile #(
   parameter logic [`REG_DATA_SIZE:0] MTVEC_RESET = 32'h0000_0100
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [2:0]                req_funct,
   input  logic [11:0]               req_addr,
   input  logic [`REG_DATA_SIZE:0]   req_src,
   input  logic [`REG_ADDR_SIZE:0]   req_rd,
   output logic [`REG_ADDR_SIZE:0]   wr_addr,
   output logic [`REG_DATA_SIZE:0]   wr_data,
   output logic                      wr_enable,
   output logic                      illegal,
   input  logic                      trap_valid,
   input  logic [`EX_WIDTH:0]        trap_cause,
   input  logic [`REG_DATA_SIZE:0]   trap_pc,
   input  logic [`REG_DATA_SIZE:0]   trap_tval,
   input  logic                      mret_valid,
   input  logic                      instr_retire,
   output logic                      redirect_valid,
   output logic [`REG_DATA_SIZE:0]   redirect_pc
);
   localparam int DW = `REG_DATA_SIZE + 1;

   typedef enum logic {IDLE, EXEC} state_t;
   state_t state, state_next;

   logic [1:0]                op_kind;
   logic [11:0]               op_addr;
   logic [`REG_DATA_SIZE:0]   op_src;
   logic [`REG_ADDR_SIZE:0]   op_rd;

   logic                      mie, mpie;
   logic [`REG_DATA_SIZE:0]   mtvec, mscratch, mepc, mcause, mtval;
`ifdef COUNTERS_EN
   logic [`REG_DATA_SIZE:0]   mcycle, minstret;
`else
   logic                      unused_counter_inputs;
   assign unused_counter_inputs = instr_retire;
`endif
   logic                      unused_funct_imm;
   assign unused_funct_imm = req_funct[2];

   logic [`REG_DATA_SIZE:0]   old_val, new_val;
   logic                      mapped, writes, illegal_op, in_exec, csr_we;
   logic                      accept, do_trap, do_mret;

   // Decode the latched address into its current value; anything not listed is unmapped.
   always_comb begin
      mapped  = 1'b1;
      old_val = '0;
      case (op_addr)
         12'h300: begin
            old_val[3] = mie;
            old_val[7] = mpie;
         end
         12'h305: old_val = mtvec;
         12'h340: old_val = mscratch;
         12'h341: old_val = mepc;
         12'h342: old_val = mcause;
         12'h343: old_val = mtval;
`ifdef COUNTERS_EN
         12'hB00, 12'hC00: old_val = mcycle;
         12'hB02: old_val = minstret;
`endif
         default: mapped = 1'b0;
      endcase
   end

   // Set/clear with a zero mask are pure reads, which keeps read-only CSRs readable.
   always_comb begin
      writes  = (op_kind == 2'b01) || (op_src != '0);
      new_val = old_val;
      case (op_kind)
         2'b01:   new_val = op_src;
         2'b10:   new_val = old_val | op_src;
         2'b11:   new_val = old_val & ~op_src;
         default: new_val = old_val;
      endcase
   end

   assign illegal_op = !mapped || (op_kind == 2'b00) || (writes && (op_addr[11:10] == 2'b11));
   assign in_exec    = reset && (state == EXEC);
   assign csr_we     = in_exec && writes && !illegal_op;
   assign do_trap    = reset && (state == IDLE) && trap_valid;
   assign do_mret    = reset && (state == IDLE) && !trap_valid && mret_valid;
   assign req_ready  = reset && (state == IDLE) && !trap_valid && !mret_valid;
   assign accept     = req_valid && req_ready;

   assign wr_enable      = in_exec && !illegal_op && (op_rd != '0);
   assign wr_addr        = in_exec ? op_rd : '0;
   assign wr_data        = in_exec ? old_val : '0;
   assign illegal        = in_exec && illegal_op;
   assign redirect_valid = do_trap || do_mret;
   assign redirect_pc    = do_trap ? mtvec : (do_mret ? mepc : '0);

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = EXEC;
         EXEC:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Counter increments come first so a CSR write later in the block takes precedence.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         op_kind  <= '0;
         op_addr  <= '0;
         op_src   <= '0;
         op_rd    <= '0;
         mie      <= 1'b0;
         mpie     <= 1'b0;
         mtvec    <= MTVEC_RESET;
         mscratch <= '0;
         mepc     <= '0;
         mcause   <= '0;
         mtval    <= '0;
`ifdef COUNTERS_EN
         mcycle   <= '0;
         minstret <= '0;
`endif
      end else begin
         state <= state_next;
`ifdef COUNTERS_EN
         mcycle <= mcycle + 1'b1;
         if (instr_retire) minstret <= minstret + 1'b1;
`endif
         if (accept) begin
            op_kind <= req_funct[1:0];
            op_addr <= req_addr;
            op_src  <= req_src;
            op_rd   <= req_rd;
         end
         if (do_trap) begin
            mepc   <= trap_pc & ~(DW'(3));
            mcause <= {{(DW - `EX_WIDTH - 1){1'b0}}, trap_cause};
            mtval  <= trap_tval;
            mpie   <= mie;
            mie    <= 1'b0;
         end
         if (do_mret) begin
            mie  <= mpie;
            mpie <= 1'b1;
         end
         if (csr_we) begin
            case (op_addr)
               12'h300: begin
                  mie  <= new_val[3];
                  mpie <= new_val[7];
               end
               12'h305: mtvec    <= new_val & ~(DW'(3));
               12'h340: mscratch <= new_val;
               12'h341: mepc     <= new_val & ~(DW'(3));
               12'h342: mcause   <= new_val;
               12'h343: mtval    <= new_val;
`ifdef COUNTERS_EN
               12'hB00: mcycle   <= new_val;
               12'hB02: minstret <= new_val;
`endif
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_csr_regfile.sv
// Directed bench for csr_regfile: vector table of CSR ops plus trap/MRET, reset-abort and counter sequences.
`ifndef REG_DATA_SIZE
`define REG_DATA_SIZE 31
`endif
`ifndef REG_ADDR_SIZE
`define REG_ADDR_SIZE 4
`endif
`ifndef EX_WIDTH
`define EX_WIDTH 4
`endif

module tb_csr_regfile;
   logic                      clk = 1'b0;
   logic                      reset;
   logic                      req_valid, req_ready;
   logic [2:0]                req_funct;
   logic [11:0]               req_addr;
   logic [`REG_DATA_SIZE:0]   req_src;
   logic [`REG_ADDR_SIZE:0]   req_rd;
   logic [`REG_ADDR_SIZE:0]   wr_addr;
   logic [`REG_DATA_SIZE:0]   wr_data;
   logic                      wr_enable, illegal;
   logic                      trap_valid;
   logic [`EX_WIDTH:0]        trap_cause;
   logic [`REG_DATA_SIZE:0]   trap_pc, trap_tval;
   logic                      mret_valid, instr_retire;
   logic                      redirect_valid;
   logic [`REG_DATA_SIZE:0]   redirect_pc;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   csr_regfile dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_funct(req_funct),
      .req_addr(req_addr), .req_src(req_src), .req_rd(req_rd),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_enable(wr_enable), .illegal(illegal),
      .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_tval(trap_tval),
      .mret_valid(mret_valid), .instr_retire(instr_retire),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   typedef struct {
      string       name;
      logic [2:0]  funct;
      logic [11:0] addr;
      logic [31:0] src;
      logic [4:0]  rd;
      logic        exp_ill;
      logic        exp_wen;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs[$];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One request through handshake and EXEC; the EXEC-cycle outputs are checked at the negedge.
   task automatic applyStimulus(input vec_t v);
      int waited = 0;
      @(negedge clk);
      req_valid = 1'b1;
      req_funct = v.funct;
      req_addr  = v.addr;
      req_src   = v.src;
      req_rd    = v.rd;
      #1;
      while (!req_ready && waited < 10) begin
         @(negedge clk);
         #1;
         waited++;
      end
      if (!req_ready) begin
         checkOutput({v.name, "_ready_timeout"}, 32'(req_ready), 32'd1);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      checkOutput({v.name, "_illegal"}, 32'(illegal), 32'(v.exp_ill));
      checkOutput({v.name, "_wr_enable"}, 32'(wr_enable), 32'(v.exp_wen));
      if (v.exp_wen) begin
         checkOutput({v.name, "_wr_data"}, wr_data, v.exp_data);
         checkOutput({v.name, "_wr_addr"}, 32'(wr_addr), 32'(v.rd));
      end
   endtask

   function automatic vec_t mk(input string n, input logic [2:0] f, input logic [11:0] a,
                               input logic [31:0] s, input logic [4:0] rd,
                               input logic ill, input logic wen, input logic [31:0] d);
      vec_t v;
      v.name = n; v.funct = f; v.addr = a; v.src = s; v.rd = rd;
      v.exp_ill = ill; v.exp_wen = wen; v.exp_data = d;
      return v;
   endfunction

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b0; req_valid = 1'b0; req_funct = '0; req_addr = '0; req_src = '0; req_rd = '0;
      trap_valid = 1'b0; trap_cause = '0; trap_pc = '0; trap_tval = '0;
      mret_valid = 1'b0; instr_retire = 1'b0;

      vecs.push_back(mk("rw_mscratch",    3'b001, 12'h340, 32'hDEAD_BEEF, 5'd5,  0, 1, 32'h0));
      vecs.push_back(mk("rs_mscratch",    3'b010, 12'h340, 32'h0,         5'd6,  0, 1, 32'hDEAD_BEEF));
      vecs.push_back(mk("rw_mstatus",     3'b001, 12'h300, 32'hFFFF_FFFF, 5'd1,  0, 1, 32'h0));
      vecs.push_back(mk("rd_mstatus_88",  3'b010, 12'h300, 32'h0,         5'd2,  0, 1, 32'h88));
      vecs.push_back(mk("rc_mpie",        3'b011, 12'h300, 32'h80,        5'd3,  0, 1, 32'h88));
      vecs.push_back(mk("rc_mie",         3'b011, 12'h300, 32'h8,         5'd4,  0, 1, 32'h8));
      vecs.push_back(mk("rd_rd0",         3'b010, 12'h300, 32'h0,         5'd0,  0, 0, 32'h0));
      vecs.push_back(mk("rd_mstatus_0",   3'b010, 12'h300, 32'h0,         5'd1,  0, 1, 32'h0));
      vecs.push_back(mk("rw_mtvec",       3'b001, 12'h305, 32'h203,       5'd7,  0, 1, 32'h100));
      vecs.push_back(mk("rd_mtvec",       3'b010, 12'h305, 32'h0,         5'd8,  0, 1, 32'h200));
      vecs.push_back(mk("restore_mtvec",  3'b001, 12'h305, 32'h100,       5'd9,  0, 1, 32'h200));
      vecs.push_back(mk("rw_c00_illegal", 3'b001, 12'hC00, 32'h1,         5'd10, 1, 0, 32'h0));
      vecs.push_back(mk("rw_7c0_illegal", 3'b001, 12'h7C0, 32'h1,         5'd10, 1, 0, 32'h0));
      vecs.push_back(mk("rsi_mscratch",   3'b110, 12'h340, 32'h10,        5'd11, 0, 1, 32'hDEAD_BEEF));
      vecs.push_back(mk("rci_mscratch",   3'b111, 12'h340, 32'h0F,        5'd12, 0, 1, 32'hDEAD_BEFF));
      vecs.push_back(mk("rd_mscratch",    3'b010, 12'h340, 32'h0,         5'd12, 0, 1, 32'hDEAD_BEF0));
      vecs.push_back(mk("rwi_mcause",     3'b101, 12'h342, 32'h5,         5'd13, 0, 1, 32'h0));
      vecs.push_back(mk("rd_mcause",      3'b010, 12'h342, 32'h0,         5'd14, 0, 1, 32'h5));
      vecs.push_back(mk("rw_mtval",       3'b001, 12'h343, 32'h1234,      5'd15, 0, 1, 32'h0));
      vecs.push_back(mk("rd_mtval",       3'b010, 12'h343, 32'h0,         5'd1,  0, 1, 32'h1234));
      vecs.push_back(mk("rw_mepc",        3'b001, 12'h341, 32'h207,       5'd2,  0, 1, 32'h0));
      vecs.push_back(mk("rd_mepc",        3'b010, 12'h341, 32'h0,         5'd3,  0, 1, 32'h204));
`ifndef COUNTERS_EN
      vecs.push_back(mk("rd_b00_illegal", 3'b010, 12'hB00, 32'h0,         5'd1,  1, 0, 32'h0));
`endif

      // Reset state
      repeat (2) @(negedge clk);
      checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
      checkOutput("reset_wr_enable", 32'(wr_enable), 32'd0);
      checkOutput("reset_redirect", 32'(redirect_valid), 32'd0);
      checkOutput("reset_illegal", 32'(illegal), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("post_reset_ready", 32'(req_ready), 32'd1);

      for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

      // Trap with a simultaneous request: trap wins, request accepted afterwards
      applyStimulus(mk("set_mie", 3'b001, 12'h300, 32'h8, 5'd0, 0, 0, 32'h0));
      @(negedge clk);
      trap_valid = 1'b1; trap_cause = 5'd2; trap_pc = 32'h204; trap_tval = 32'hBAD;
      req_valid = 1'b1; req_funct = 3'b010; req_addr = 12'h300; req_src = '0; req_rd = 5'd4;
      #1;
      checkOutput("trap_req_ready", 32'(req_ready), 32'd0);
      checkOutput("trap_redirect_valid", 32'(redirect_valid), 32'd1);
      checkOutput("trap_redirect_pc", redirect_pc, 32'h100);
      @(posedge clk);
      #1 trap_valid = 1'b0;
      @(negedge clk);
      checkOutput("trap_redirect_pulse", 32'(redirect_valid), 32'd0);
      checkOutput("after_trap_ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      checkOutput("after_trap_wen", 32'(wr_enable), 32'd1);
      checkOutput("after_trap_mstatus", wr_data, 32'h80);
      applyStimulus(mk("trap_mepc",   3'b010, 12'h341, 32'h0, 5'd1, 0, 1, 32'h204));
      applyStimulus(mk("trap_mcause", 3'b010, 12'h342, 32'h0, 5'd1, 0, 1, 32'h2));
      applyStimulus(mk("trap_mtval",  3'b010, 12'h343, 32'h0, 5'd1, 0, 1, 32'hBAD));

      // MRET back to mepc and restore MIE from MPIE
      @(negedge clk);
      mret_valid = 1'b1;
      #1;
      checkOutput("mret_redirect_valid", 32'(redirect_valid), 32'd1);
      checkOutput("mret_redirect_pc", redirect_pc, 32'h204);
      checkOutput("mret_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1 mret_valid = 1'b0;
      applyStimulus(mk("mret_mstatus", 3'b010, 12'h300, 32'h0, 5'd1, 0, 1, 32'h88));

      // Reset asserted during EXEC aborts the op and restores reset values
      applyStimulus(mk("set_mtvec", 3'b001, 12'h305, 32'h300, 5'd0, 0, 0, 32'h0));
      @(negedge clk);
      req_valid = 1'b1; req_funct = 3'b001; req_addr = 12'h340; req_src = 32'h55; req_rd = 5'd5;
      @(posedge clk);
      #1 req_valid = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("abort_wr_enable", 32'(wr_enable), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      applyStimulus(mk("abort_mscratch", 3'b010, 12'h340, 32'h0, 5'd1, 0, 1, 32'h0));
      applyStimulus(mk("reset_mtvec",    3'b010, 12'h305, 32'h0, 5'd1, 0, 1, 32'h100));

`ifdef COUNTERS_EN
      // mcycle wraps from all-ones; cycle alias follows mcycle; minstret counts retires
      applyStimulus(mk("preset_mcycle", 3'b001, 12'hB00, 32'hFFFF_FFFF, 5'd0, 0, 0, 32'h0));
      applyStimulus(mk("mcycle_wrap",   3'b010, 12'hB00, 32'h0, 5'd1, 0, 1, 32'h0));
      applyStimulus(mk("cycle_alias",   3'b010, 12'hC00, 32'h0, 5'd2, 0, 1, 32'h2));
      applyStimulus(mk("preset_minstret", 3'b001, 12'hB02, 32'h5, 5'd0, 0, 0, 32'h0));
      @(negedge clk);
      instr_retire = 1'b1;
      @(negedge clk);
      instr_retire = 1'b0;
      applyStimulus(mk("minstret_count", 3'b010, 12'hB02, 32'h0, 5'd3, 0, 1, 32'h6));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
